// File: rtl/dot_product_loader_if.sv
// dot_product_loader_if: element-pair input stream and result output stream
// of the dot product loader, each a valid/ready handshake.
interface dot_product_loader_if #(
    parameter int DW = 8,
    parameter int RW = 19
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_a;
    logic [DW-1:0] in_b;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] out_data;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/dot_product.sv
// dot_product: combinational unsigned dot product of two packed N-element vectors;
// the sum is kept at full width, so N*(2^DW-1)^2 never overflows.
module dot_product #(
    parameter int N     = 8,
    parameter int N_bit = 3,
    parameter int DW    = 8
) (
    input  logic [DW*N-1:0]        inp1,
    input  logic [DW*N-1:0]        inp2,
    output logic [2*DW+N_bit-1:0]  outp
);
    always_comb begin
        outp = '0;
        for (int i = 0; i < N; i++)
            outp = outp + (2*DW+N_bit)'(inp1[i*DW +: DW]) * (2*DW+N_bit)'(inp2[i*DW +: DW]);
    end
endmodule

// File: rtl/dot_product_loader.sv
// dot_product_loader: packs N streamed (a, b) pairs into operand vectors for a
// combinational dot_product, registers its result and presents it downstream.
module dot_product_loader #(
    parameter int N     = 8,
    parameter int N_bit = 3,
    parameter int DW    = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    dot_product_loader_if.slave    s,
    output logic [DW*N-1:0]        vec_a,
    output logic [DW*N-1:0]        vec_b,
    input  logic [2*DW+N_bit-1:0]  dp_result
);
    typedef enum logic [1:0] {LOAD, CALC, OUT} state_t;

    state_t         state, state_nx;
    logic [N_bit:0] idx;
    logic           acc;
    logic           last;

    assign acc  = s.in_valid && s.in_ready;
    assign last = idx == (N_bit+1)'(N-1);

    // handshake outputs decode the registered state only, never the inputs
    always_comb begin
        state_nx   = state;
        s.in_ready = state == LOAD;
        s.out_valid = state == OUT;
        if (state == LOAD && acc && last)
            state_nx = CALC;
        else if (state == CALC)
            state_nx = OUT;
        else if (state == OUT && s.out_ready)
            state_nx = LOAD;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= LOAD;
            idx        <= '0;
            vec_a      <= '0;
            vec_b      <= '0;
            s.out_data <= '0;
        end else begin
            state <= state_nx;
            if (acc) begin
                vec_a[idx*DW +: DW] <= s.in_a;
                vec_b[idx*DW +: DW] <= s.in_b;
                idx                 <= last ? '0 : idx + 1'b1;
            end
            if (state == CALC)
                s.out_data <= dp_result;
        end
    end
endmodule
